// File: rtl/sumfour_checker_if.sv
// Signal bundle between a sumfour counter source and its sequence checker.
// master drives the samples and controls; slave (the checker) returns status.
interface sumfour_checker_if #(
    parameter int CNT_W = 4,
    parameter int ERR_W = 16
);
    logic             i_en;
    logic             i_clr;
    logic [CNT_W-1:0] i_cnt_1;
    logic [CNT_W-1:0] i_cnt_2;
    logic             o_locked_1;
    logic             o_locked_2;
    logic             o_err_1;
    logic             o_err_2;
    logic [ERR_W-1:0] o_err_cnt_1;
    logic [ERR_W-1:0] o_err_cnt_2;
    logic [ERR_W-1:0] o_wrap_cnt;
    logic             o_sticky_err;

    modport master (
        output i_en, i_clr, i_cnt_1, i_cnt_2,
        input  o_locked_1, o_locked_2, o_err_1, o_err_2,
               o_err_cnt_1, o_err_cnt_2, o_wrap_cnt, o_sticky_err
    );

    modport slave (
        input  i_en, i_clr, i_cnt_1, i_cnt_2,
        output o_locked_1, o_locked_2, o_err_1, o_err_2,
               o_err_cnt_1, o_err_cnt_2, o_wrap_cnt, o_sticky_err
    );
endinterface

// File: rtl/sumfour_checker.sv
// Two-channel +1-per-sample sequence monitor with lock tracking and saturating error/wrap counters.
// Status is registered one cycle after the sampling edge; never stalls, samples every enabled cycle.
module sumfour_checker #(
    parameter int CNT_W      = 4,
    parameter int LOCK_CNT   = 4,
    parameter int LOSS_CNT   = 2,
    parameter int ERR_W      = 16,
    parameter bit ALLOW_HOLD = 1'b0
) (
    input logic              clk,
    input logic              rst,
    sumfour_checker_if.slave bus
);
    localparam int NCH = 2;
    localparam int GW  = $clog2(LOCK_CNT + 1);
    localparam int BW  = $clog2(LOSS_CNT + 1);
    localparam logic [GW-1:0]    LOCK_LAST = GW'(LOCK_CNT - 1);
    localparam logic [BW-1:0]    LOSS_LAST = BW'(LOSS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t state      [NCH];
    state_t next_state [NCH];

    logic [NCH-1:0][CNT_W-1:0] cnt;
    logic [NCH-1:0][CNT_W-1:0] prev;
    logic [NCH-1:0]            prev_valid;
    logic [NCH-1:0][GW-1:0]    good_run;
    logic [NCH-1:0][BW-1:0]    bad_run;
    logic [NCH-1:0][ERR_W-1:0] err_cnt;
    logic [NCH-1:0]            err_q;
    logic [ERR_W-1:0]          wrap_cnt;
    logic                      sticky;

    logic [NCH-1:0] check;
    logic [NCH-1:0] good;
    logic [NCH-1:0] locked;
    logic [NCH-1:0] err_evt;
    logic           wrap_evt;

    assign cnt = {bus.i_cnt_2, bus.i_cnt_1};

    // A transition is only judged once a previous sample exists in this enabled run.
    always_comb begin
        check = '0;
        good  = '0;
        for (int c = 0; c < NCH; c++) begin
            check[c] = bus.i_en & prev_valid[c];
            good[c]  = (cnt[c] == prev[c] + CNT_W'(1)) ||
                       (ALLOW_HOLD && (cnt[c] == prev[c]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) state[c] <= SEARCH;
        end else begin
            for (int c = 0; c < NCH; c++) state[c] <= next_state[c];
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            next_state[c] = state[c];
            case (state[c])
                SEARCH: if (check[c] && good[c] && (good_run[c] == LOCK_LAST))
                            next_state[c] = LOCKED;
                LOCKED: if (check[c] && !good[c] && (bad_run[c] == LOSS_LAST))
                            next_state[c] = SEARCH;
                default: next_state[c] = SEARCH;
            endcase
        end
    end

    always_comb begin
        locked  = '0;
        err_evt = '0;
        for (int c = 0; c < NCH; c++) begin
            locked[c]  = (state[c] == LOCKED);
            err_evt[c] = check[c] & ~good[c] & (state[c] == LOCKED);
        end
        wrap_evt = check[0] & good[0] & (state[0] == LOCKED) &
                   (prev[0] == CNT_MAX) & (cnt[0] == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev       <= '0;
            prev_valid <= '0;
            good_run   <= '0;
            bad_run    <= '0;
            err_q      <= '0;
        end else begin
            err_q <= err_evt;
            for (int c = 0; c < NCH; c++) begin
                if (!bus.i_en) begin
                    prev_valid[c] <= 1'b0;
                end else begin
                    prev[c]       <= cnt[c];
                    prev_valid[c] <= 1'b1;
                end
                // Run counters restart on every state change and on the opposite kind of transition.
                if (check[c]) begin
                    if (!locked[c]) begin
                        bad_run[c] <= '0;
                        if (good[c] && (good_run[c] != LOCK_LAST))
                            good_run[c] <= good_run[c] + GW'(1);
                        else
                            good_run[c] <= '0;
                    end else begin
                        good_run[c] <= '0;
                        if (!good[c] && (bad_run[c] != LOSS_LAST))
                            bad_run[c] <= bad_run[c] + BW'(1);
                        else
                            bad_run[c] <= '0;
                    end
                end
            end
        end
    end

    // Clear takes priority over any increment or sticky set on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt  <= '0;
            wrap_cnt <= '0;
            sticky   <= 1'b0;
        end else if (bus.i_clr) begin
            err_cnt  <= '0;
            wrap_cnt <= '0;
            sticky   <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (err_evt[c] && (err_cnt[c] != ERR_MAX))
                    err_cnt[c] <= err_cnt[c] + ERR_W'(1);
            end
            if (wrap_evt && (wrap_cnt != ERR_MAX))
                wrap_cnt <= wrap_cnt + ERR_W'(1);
            if (|err_evt)
                sticky <= 1'b1;
        end
    end

    assign bus.o_locked_1   = locked[0];
    assign bus.o_locked_2   = locked[1];
    assign bus.o_err_1      = err_q[0];
    assign bus.o_err_2      = err_q[1];
    assign bus.o_err_cnt_1  = err_cnt[0];
    assign bus.o_err_cnt_2  = err_cnt[1];
    assign bus.o_wrap_cnt   = wrap_cnt;
    assign bus.o_sticky_err = sticky;
endmodule

// File: tb/tb_sumfour_checker.sv
// Randomized and directed bench for sumfour_checker: three parameterisations against one sequence model.
module tb_sumfour_checker;
    localparam int ND   = 3;
    localparam int LOCK = 4;
    localparam int LOSS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] c1  = '0;
    logic [3:0] c2  = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sumfour_checker_if              if_a ();
    sumfour_checker_if              if_h ();
    sumfour_checker_if #(.ERR_W(4)) if_s ();

    assign if_a.i_en = en;  assign if_a.i_clr = clr;  assign if_a.i_cnt_1 = c1;  assign if_a.i_cnt_2 = c2;
    assign if_h.i_en = en;  assign if_h.i_clr = clr;  assign if_h.i_cnt_1 = c1;  assign if_h.i_cnt_2 = c2;
    assign if_s.i_en = en;  assign if_s.i_clr = clr;  assign if_s.i_cnt_1 = c1;  assign if_s.i_cnt_2 = c2;

    sumfour_checker                         u_a (.clk(clk), .rst(rst), .bus(if_a));
    sumfour_checker #(.ALLOW_HOLD(1'b1))    u_h (.clk(clk), .rst(rst), .bus(if_h));
    sumfour_checker #(.ERR_W(4))            u_s (.clk(clk), .rst(rst), .bus(if_s));

    // Model: index 0 = defaults, 1 = hold allowed, 2 = 4-bit counters.
    int m_prev  [ND][2];
    bit m_pv    [ND][2];
    bit m_lock  [ND][2];
    int m_gr    [ND][2];
    int m_br    [ND][2];
    bit m_err   [ND][2];
    int m_ecnt  [ND][2];
    int m_wrap  [ND];
    bit m_stick [ND];

    function automatic int emax(input int d);
        return (d == 2) ? 15 : 65535;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < 2; c++) begin
                m_prev[d][c] = 0; m_pv[d][c] = 0; m_lock[d][c] = 0;
                m_gr[d][c] = 0;   m_br[d][c] = 0; m_err[d][c] = 0; m_ecnt[d][c] = 0;
            end
            m_wrap[d]  = 0;
            m_stick[d] = 0;
        end
    endtask

    task automatic model_edge();
        int v;
        bit g;
        bit ev;
        if (rst) return;
        for (int d = 0; d < ND; d++) begin
            ev = 1'b0;
            for (int c = 0; c < 2; c++) begin
                v = (c == 0) ? int'(c1) : int'(c2);
                m_err[d][c] = 1'b0;
                if (!en) begin
                    m_pv[d][c] = 1'b0;
                end else if (!m_pv[d][c]) begin
                    m_prev[d][c] = v;
                    m_pv[d][c]   = 1'b1;
                end else begin
                    g = (v == (m_prev[d][c] + 1) % 16) || (d == 1 && v == m_prev[d][c]);
                    if (!m_lock[d][c]) begin
                        if (!g) m_gr[d][c] = 0;
                        else if (m_gr[d][c] + 1 == LOCK) begin m_lock[d][c] = 1; m_gr[d][c] = 0; end
                        else m_gr[d][c]++;
                    end else if (g) begin
                        m_br[d][c] = 0;
                        if (c == 0 && m_prev[d][c] == 15 && v == 0 && m_wrap[d] < emax(d)) m_wrap[d]++;
                    end else begin
                        m_err[d][c] = 1'b1;
                        ev = 1'b1;
                        if (m_ecnt[d][c] < emax(d)) m_ecnt[d][c]++;
                        if (m_br[d][c] + 1 == LOSS) begin
                            m_lock[d][c] = 0; m_br[d][c] = 0; m_gr[d][c] = 0;
                        end else m_br[d][c]++;
                    end
                    m_prev[d][c] = v;
                end
            end
            if (clr) begin
                m_ecnt[d][0] = 0; m_ecnt[d][1] = 0; m_wrap[d] = 0; m_stick[d] = 0;
            end else if (ev) m_stick[d] = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int d, input logic l1, input logic l2, input logic e1, input logic e2,
                           input logic [31:0] ec1, input logic [31:0] ec2, input logic [31:0] wr,
                           input logic st);
        check($sformatf("d%0d_locked_1", d), 32'(l1), int'(m_lock[d][0]));
        check($sformatf("d%0d_locked_2", d), 32'(l2), int'(m_lock[d][1]));
        check($sformatf("d%0d_err_1", d),    32'(e1), int'(m_err[d][0]));
        check($sformatf("d%0d_err_2", d),    32'(e2), int'(m_err[d][1]));
        check($sformatf("d%0d_err_cnt_1", d), ec1, m_ecnt[d][0]);
        check($sformatf("d%0d_err_cnt_2", d), ec2, m_ecnt[d][1]);
        check($sformatf("d%0d_wrap_cnt", d),  wr,  m_wrap[d]);
        check($sformatf("d%0d_sticky", d), 32'(st), int'(m_stick[d]));
    endtask

    always @(negedge clk) begin
        cmp_dut(0, if_a.o_locked_1, if_a.o_locked_2, if_a.o_err_1, if_a.o_err_2,
                32'(if_a.o_err_cnt_1), 32'(if_a.o_err_cnt_2), 32'(if_a.o_wrap_cnt), if_a.o_sticky_err);
        cmp_dut(1, if_h.o_locked_1, if_h.o_locked_2, if_h.o_err_1, if_h.o_err_2,
                32'(if_h.o_err_cnt_1), 32'(if_h.o_err_cnt_2), 32'(if_h.o_wrap_cnt), if_h.o_sticky_err);
        cmp_dut(2, if_s.o_locked_1, if_s.o_locked_2, if_s.o_err_1, if_s.o_err_2,
                32'(if_s.o_err_cnt_1), 32'(if_s.o_err_cnt_2), 32'(if_s.o_wrap_cnt), if_s.o_sticky_err);
    end

    task automatic step(input bit e, input bit k, input int v1, input int v2);
        en  = e;
        clr = k;
        c1  = 4'(v1);
        c2  = 4'(v2);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic int next_val(input int v);
        int r;
        r = $urandom_range(0, 99);
        if (r < 85)      return (v + 1) % 16;
        else if (r < 92) return v;
        else             return int'($urandom_range(0, 15));
    endfunction

    initial begin
        int p2a [6] = '{2, 3, 4, 7, 8, 9};
        int p2b [6] = '{2, 3, 4, 5, 6, 7};
        int p3a [7] = '{10, 11, 12, 13, 14, 15, 0};
        int p3b [7] = '{8, 12, 2, 3, 4, 5, 6};
        int p4a [4] = '{1, 1, 1, 2};
        int p4b [4] = '{7, 8, 9, 10};
        int v1;
        int v2;
        bit e;
        bit k;

        model_reset();
        #12;
        check("rst_locked_1", 32'(if_a.o_locked_1), 0);
        check("rst_err_cnt_1", 32'(if_a.o_err_cnt_1), 0);
        check("rst_sticky", 32'(if_a.o_sticky_err), 0);
        rst = 1'b0;

        // Lock-in from priming, then a full lap through 15->0.
        for (int v = 0; v <= 4; v++) begin
            step(1, 0, v, v);
            if (v == 3) check("p1_locked_early", 32'(if_a.o_locked_1), 0);
        end
        check("p1_locked_1", 32'(if_a.o_locked_1), 1);
        check("p1_locked_2", 32'(if_a.o_locked_2), 1);
        for (int v = 5; v <= 17; v++) step(1, 0, v, v);
        check("p1_wrap", 32'(if_a.o_wrap_cnt), 1);
        check("p1_err_cnt_1", 32'(if_a.o_err_cnt_1), 0);
        check("p1_sticky", 32'(if_a.o_sticky_err), 0);

        // Single isolated error on channel 1.
        for (int i = 0; i < 6; i++) begin
            step(1, 0, p2a[i], p2b[i]);
            if (i == 3) begin
                check("p2_err_1", 32'(if_a.o_err_1), 1);
                check("p2_err_cnt_1", 32'(if_a.o_err_cnt_1), 1);
                check("p2_sticky", 32'(if_a.o_sticky_err), 1);
                check("p2_err_2", 32'(if_a.o_err_2), 0);
            end
            if (i == 4) check("p2_err_1_drop", 32'(if_a.o_err_1), 0);
        end
        check("p2_locked_1", 32'(if_a.o_locked_1), 1);

        // Two consecutive errors on channel 2 lose lock, then relock.
        for (int i = 0; i < 7; i++) begin
            step(1, 0, p3a[i], p3b[i]);
            if (i == 1) check("p3_locked_2_hold", 32'(if_a.o_locked_2), 1);
            if (i == 2) begin
                check("p3_locked_2_lost", 32'(if_a.o_locked_2), 0);
                check("p3_err_cnt_2", 32'(if_a.o_err_cnt_2), 2);
            end
            if (i == 5) check("p3_relock_early", 32'(if_a.o_locked_2), 0);
        end
        check("p3_relock", 32'(if_a.o_locked_2), 1);

        // Held values: errors without hold, tolerated with hold.
        for (int i = 0; i < 4; i++) step(1, 0, p4a[i], p4b[i]);
        check("p4_a_locked_1", 32'(if_a.o_locked_1), 0);
        check("p4_a_err_cnt_1", 32'(if_a.o_err_cnt_1), 3);
        check("p4_h_locked_1", 32'(if_h.o_locked_1), 1);
        check("p4_h_err_cnt_1", 32'(if_h.o_err_cnt_1), 1);

        // Relock, then async reset mid-cycle.
        for (int i = 0; i < 4; i++) step(1, 0, 3 + i, 11 + i);
        check("p5_locked_pre", 32'(if_a.o_locked_1), 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("p5_rst_locked_1", 32'(if_a.o_locked_1), 0);
        check("p5_rst_locked_2", 32'(if_a.o_locked_2), 0);
        check("p5_rst_err_cnt_1", 32'(if_a.o_err_cnt_1), 0);
        check("p5_rst_err_cnt_2", 32'(if_a.o_err_cnt_2), 0);
        check("p5_rst_wrap", 32'(if_a.o_wrap_cnt), 0);
        check("p5_rst_sticky", 32'(if_a.o_sticky_err), 0);
        step(1, 0, 7, 15);
        step(1, 0, 8, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 9 + i, 9 + i);
            if (i == 3) check("p5_relock_early", 32'(if_a.o_locked_1), 0);
        end
        check("p5_relock", 32'(if_a.o_locked_1), 1);

        // Twenty isolated errors saturate the 4-bit counter; clear beats a coincident error.
        v1 = 13;
        v2 = 13;
        for (int i = 0; i < 20; i++) begin
            v1 += 2; v2++; step(1, 0, v1, v2);
            v1++;    v2++; step(1, 0, v1, v2);
        end
        check("p6_s_sat", 32'(if_s.o_err_cnt_1), 15);
        check("p6_a_cnt", 32'(if_a.o_err_cnt_1), 20);
        check("p6_s_locked", 32'(if_s.o_locked_1), 1);
        v1 += 2; v2++;
        step(1, 1, v1, v2);
        check("p6_clr_err_cnt", 32'(if_s.o_err_cnt_1), 0);
        check("p6_clr_sticky", 32'(if_s.o_sticky_err), 0);
        check("p6_clr_pulse", 32'(if_s.o_err_1), 1);
        check("p6_clr_wrap", 32'(if_a.o_wrap_cnt), 0);
        v1++; v2++;
        step(1, 0, v1, v2);

        // Random phase with occasional disables, clears and async reset pulses.
        v1 = v1 % 16;
        v2 = v2 % 16;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 999) < 3) begin
                #2;
                rst = 1'b1;
                model_reset();
                #1;
                rst = 1'b0;
            end
            e  = ($urandom_range(0, 99) < 93);
            k  = ($urandom_range(0, 99) < 2);
            v1 = next_val(v1);
            v2 = next_val(v2);
            step(e, k, v1, v2);
        end

        #6;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
